// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and flush
module id_ex_stage #(
   parameter int DATA_W  = 8,
   parameter int RADDR_W = 2,
   parameter int IMM_W   = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [5:0]         id_ctrl,
   input  logic [DATA_W-1:0]  id_rs_data,
   input  logic [DATA_W-1:0]  id_rt_data,
   input  logic [IMM_W-1:0]   id_imm,
   input  logic [RADDR_W-1:0] id_rs_addr,
   input  logic [RADDR_W-1:0] id_rt_addr,
   input  logic [RADDR_W-1:0] id_dst_addr,
   input  logic               flush,
   input  logic               ex_hold,
   output logic               ex_valid,
   output logic [5:0]         ex_ctrl,
   output logic [DATA_W-1:0]  ex_rs_data,
   output logic [DATA_W-1:0]  ex_rt_data,
   output logic [IMM_W-1:0]   ex_imm,
   output logic [RADDR_W-1:0] ex_rs_addr,
   output logic [RADDR_W-1:0] ex_rt_addr,
   output logic [RADDR_W-1:0] ex_dst_addr,
   output logic               stall_id,
   output logic [CNT_W-1:0]   bubble_cnt
);

   logic hz;

   // Conservative: any address match against a load in EX stalls, whether or not the operand is used.
   assign hz = id_valid & ex_valid & ex_ctrl[3] &
               ((ex_dst_addr == id_rs_addr) | (ex_dst_addr == id_rt_addr));

   assign stall_id = (hz & ~flush & ~ex_hold) | ex_hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= 6'b0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm      <= '0;
         ex_rs_addr  <= '0;
         ex_rt_addr  <= '0;
         ex_dst_addr <= '0;
         bubble_cnt  <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= 6'b0;
      end else if (ex_hold) begin
         ex_valid <= ex_valid;
      end else if (hz) begin
         // Clearing ex_ctrl drops memread, so the hazard cannot persist past one bubble.
         ex_valid <= 1'b0;
         ex_ctrl  <= 6'b0;
         if (bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         ex_valid    <= id_valid;
         ex_ctrl     <= id_valid ? id_ctrl : 6'b0;
         ex_rs_data  <= id_rs_data;
         ex_rt_data  <= id_rt_data;
         ex_imm      <= id_imm;
         ex_rs_addr  <= id_rs_addr;
         ex_rt_addr  <= id_rt_addr;
         ex_dst_addr <= id_dst_addr;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage against a reference model
module tb_id_ex_stage;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [5:0] id_ctrl;
   logic [7:0] id_rs_data, id_rt_data, id_imm;
   logic [1:0] id_rs_addr, id_rt_addr, id_dst_addr;
   logic       flush, ex_hold;
   logic       ex_valid;
   logic [5:0] ex_ctrl;
   logic [7:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [1:0] ex_rs_addr, ex_rt_addr, ex_dst_addr;
   logic       stall_id;
   logic [7:0] bubble_cnt;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dst_addr(id_dst_addr),
      .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_dst_addr(ex_dst_addr),
      .stall_id(stall_id), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model of the EX slot: a record of the instruction sitting there plus a plain bubble tally.
   bit       m_valid;
   bit [5:0] m_ctrl;
   bit [7:0] m_rs, m_rt, m_imm;
   bit [1:0] m_rsa, m_rta, m_dst;
   int       m_bubbles;

   localparam bit [5:0] LW  = 6'b111010;
   localparam bit [5:0] ADD = 6'b010000;
   localparam bit [5:0] LI  = 6'b010011;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_load_use();
      // A load in EX whose target register is named by the instruction in ID.
      return id_valid && m_valid && (m_ctrl == LW || m_ctrl[3]) &&
             (m_dst == id_rs_addr || m_dst == id_rt_addr);
   endfunction

   function automatic bit model_stall();
      if (ex_hold) return 1'b1;
      if (flush)   return 1'b0;
      return model_load_use();
   endfunction

   task automatic model_reset();
      m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_imm = 0;
      m_rsa = 0; m_rta = 0; m_dst = 0; m_bubbles = 0;
   endtask

   task automatic model_edge();
      if (flush) begin
         m_valid = 0; m_ctrl = 0;
      end else if (ex_hold) begin
      end else if (model_load_use()) begin
         m_valid = 0; m_ctrl = 0; m_bubbles++;
      end else begin
         m_valid = id_valid;
         m_ctrl  = id_valid ? id_ctrl : 6'b0;
         m_rs = id_rs_data; m_rt = id_rt_data; m_imm = id_imm;
         m_rsa = id_rs_addr; m_rta = id_rt_addr; m_dst = id_dst_addr;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, ex_valid, m_valid);
      check({tag, ".ctrl"}, ex_ctrl, m_ctrl);
      check({tag, ".bubbles"}, bubble_cnt, (m_bubbles > 255) ? 255 : m_bubbles);
      if (m_valid) begin
         check({tag, ".rs"}, ex_rs_data, m_rs);
         check({tag, ".rt"}, ex_rt_data, m_rt);
         check({tag, ".imm"}, ex_imm, m_imm);
         check({tag, ".rsa"}, ex_rs_addr, m_rsa);
         check({tag, ".rta"}, ex_rt_addr, m_rta);
         check({tag, ".dst"}, ex_dst_addr, m_dst);
      end
   endtask

   task automatic set_id(input bit v, input bit [5:0] c, input bit [7:0] rs, input bit [7:0] rt,
                         input bit [7:0] imm, input bit [1:0] rsa, input bit [1:0] rta, input bit [1:0] dst);
      id_valid = v; id_ctrl = c; id_rs_data = rs; id_rt_data = rt; id_imm = imm;
      id_rs_addr = rsa; id_rt_addr = rta; id_dst_addr = dst;
   endtask

   // Called one time unit after a rising edge: checks stall_id, clocks once, checks the EX slot.
   task automatic cyc(input string tag);
      #1;
      check({tag, ".stall"}, stall_id, model_stall());
      model_edge();
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      reset = 1'b1; flush = 0; ex_hold = 0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      check("reset.stall", stall_id, 1'b0);
      reset = 1'b0;

      set_id(1, LI, 8'h12, 8'h34, 8'h05, 0, 0, 2);
      cyc("pass");
      check("pass.ctrl_k", ex_ctrl, LI);
      check("pass.imm_k", ex_imm, 8'h05);
      check("pass.dst_k", ex_dst_addr, 2);

      set_id(1, LW, 8'h00, 8'h00, 8'h00, 0, 0, 1);
      cyc("lu_lw");
      set_id(1, ADD, 8'h21, 8'h43, 8'h00, 1, 2, 3);
      #1 check("lu.stall_k", stall_id, 1'b1);
      cyc("lu_bub");
      check("lu.ctrl_k", ex_ctrl, 6'b0);
      cyc("lu_add");
      check("lu.add_k", ex_ctrl, ADD);
      check("lu.cnt_k", bubble_cnt, 8'd1);

      set_id(1, LW, 0, 0, 0, 0, 0, 1);
      cyc("nh_lw");
      set_id(1, ADD, 8'h55, 8'h66, 0, 2, 3, 0);
      cyc("nh_add");
      check("nh.cnt_k", bubble_cnt, 8'd1);

      set_id(1, LW, 0, 0, 0, 0, 0, 1);
      cyc("fl_lw");
      set_id(1, ADD, 8'h77, 8'h88, 0, 1, 0, 2);
      flush = 1;
      cyc("fl_hz");
      flush = 0;
      check("fl.cnt_k", bubble_cnt, 8'd1);

      set_id(1, LI, 8'h9a, 8'hbc, 8'h3c, 3, 2, 1);
      cyc("hd_pre");
      ex_hold = 1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 6'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                2'($urandom), 2'($urandom), 2'($urandom));
         cyc("hold");
         check("hold.imm_k", ex_imm, 8'h3c);
      end
      ex_hold = 0;
      cyc("hd_rel");

      // Asynchronous reset with a load in EX and a dependent add waiting in ID.
      set_id(1, LW, 0, 0, 0, 0, 0, 1);
      cyc("rs_lw");
      set_id(1, ADD, 8'h11, 8'h22, 0, 1, 1, 0);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_outputs("rs_mid");
      check("rs_mid.stall", stall_id, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      #1 check("rs_rel.stall", stall_id, 1'b0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 2000; i++) begin
         set_id($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? LW : 6'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom),
                2'($urandom), 2'($urandom), 2'($urandom));
         flush   = ($urandom_range(0, 7) == 0);
         ex_hold = ($urandom_range(0, 7) == 0);
         cyc("rand");
      end
      flush = 0; ex_hold = 0;

      // Back-to-back dependent loads alternate capture/bubble, driving the counter past saturation.
      for (int i = 0; i < 700; i++) begin
         set_id(1, LW, 8'(i), 0, 0, 1, 0, 1);
         cyc("sat");
      end
      check("sat.cnt_k", bubble_cnt, 8'hFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
